// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, round-key word type and the state
// encoding for the key-expansion sequencer.
package aes_pkg;

  localparam int AES_NR     = 10;
  localparam int AES_NUM_RK = 11;
  localparam int AES_KEY_W  = 128;
  localparam int AES_RND_W  = 5;
  localparam int AES_IDX_W  = 4;

  // Highest valid round-key index, sized to the read-index and round-counter width
  localparam logic [AES_IDX_W-1:0] AES_LAST_IDX = 4'(AES_NR);

  typedef logic [AES_KEY_W-1:0] rk_word_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_EXPAND = 3'd2,
    ST_FINAL  = 3'd3,
    ST_DONE   = 3'd4
  } kexp_state_e;

endpackage

// File: rtl/key_scheduler.sv
// key_scheduler: one AES-128 key-expansion round per clock, registered output.
// round_i == 0 passes key_i straight through, so round key 0 comes out of the
// same register as all the others. The register has no reset on purpose; the
// sequencer never captures it outside the cycles where it holds valid data.
// Word 0 of a key is bits [127:96], and byte 0 is bits [127:120].
import aes_pkg::*;

module key_scheduler (
  input  logic                 clk,
  input  logic [AES_RND_W-1:0] round_i,
  input  rk_word_t             key_i,
  output rk_word_t             key_o
);

  // Forward S-box, entry 0 in the most significant byte
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    // entry b sits at bit offset (255-b)*8 == {~b, 3'b000}
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [AES_RND_W-1:0] r);
    case (r)
      5'd1:    return 8'h01;
      5'd2:    return 8'h02;
      5'd3:    return 8'h04;
      5'd4:    return 8'h08;
      5'd5:    return 8'h10;
      5'd6:    return 8'h20;
      5'd7:    return 8'h40;
      5'd8:    return 8'h80;
      5'd9:    return 8'h1b;
      5'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic rk_word_t next_rk(input rk_word_t k, input logic [AES_RND_W-1:0] r);
    logic [31:0] w0, w1, w2, w3, rot, t, n0, n1, n2, n3;
    w0  = k[127:96];
    w1  = k[95:64];
    w2  = k[63:32];
    w3  = k[31:0];
    rot = {w3[23:0], w3[31:24]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
          ^ {rcon(r), 24'h0};
    n0  = w0 ^ t;
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Register one expansion step (or pass-through for round 0)
  always_ff @(posedge clk) begin
    key_o <= (round_i == '0) ? key_i : next_rk(key_i, round_i);
  end

endmodule

// File: rtl/key_expansion_ctrl.sv
// key_expansion_ctrl: drives key_scheduler through rounds 0..10, feeding each
// result back as the next input, and captures all 11 round keys into a store
// read combinationally by index.
// Optional build macro KEYEXP_DEC_ORDER_EN adds rk_rd_dec_i, which reverses
// the index (rk[10-idx]) for decryption-order reads.
//
// state  | meaning
// IDLE   | no schedule ever requested since reset
// LOAD   | scheduler passing key_q through as round key 0
// EXPAND | cnt=k: capture rk[k-1], scheduler computes rk[k]
// FINAL  | capture rk[10], pulse done
// DONE   | store valid; a new start restarts expansion
import aes_pkg::*;

module key_expansion_ctrl (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  rk_word_t             key_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 keys_valid_o,
  input  logic [AES_IDX_W-1:0] rk_rd_idx_i,
`ifdef KEYEXP_DEC_ORDER_EN
  input  logic                 rk_rd_dec_i,
`endif
  output rk_word_t             rk_rd_data_o
);

  kexp_state_e          state_q;
  logic [AES_IDX_W-1:0] cnt_q;
  rk_word_t             key_q;
  rk_word_t             rk_q [0:AES_NUM_RK-1];
  logic                 busy_q, done_q, keys_valid_q;

  logic [AES_RND_W-1:0] sched_round_d;
  rk_word_t             sched_key_d;
  rk_word_t             sched_out;
  logic [AES_IDX_W-1:0] rd_sel_d;

  key_scheduler u_key_sched (
    .clk     (clk),
    .round_i (sched_round_d),
    .key_i   (sched_key_d),
    .key_o   (sched_out)
  );

  // Scheduler drive: load the sampled key once, then chain its own output
  always_comb begin
    sched_round_d = '0;
    sched_key_d   = sched_out;
    if (state_q == ST_EXPAND) sched_round_d = {1'b0, cnt_q};
    if (state_q == ST_LOAD)   sched_key_d   = key_q;
  end

  // Sequencer FSM with registered status outputs and round-key store
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      key_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      for (int i = 0; i < AES_NUM_RK; i++) rk_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            key_q        <= key_i;
            busy_q       <= 1'b1;
            keys_valid_q <= 1'b0;
            cnt_q        <= '0;
            state_q      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          cnt_q   <= 4'd1;
          state_q <= ST_EXPAND;
        end
        ST_EXPAND: begin
          rk_q[cnt_q - 4'd1] <= sched_out;
          cnt_q              <= cnt_q + 4'd1;
          if (cnt_q == AES_LAST_IDX) state_q <= ST_FINAL;
        end
        ST_FINAL: begin
          rk_q[AES_NR] <= sched_out;
          busy_q       <= 1'b0;
          done_q       <= 1'b1;
          keys_valid_q <= 1'b1;
          state_q      <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Combinational store read; out-of-range index reads as zero
  always_comb begin
    rk_rd_data_o = '0;
    rd_sel_d     = rk_rd_idx_i;
`ifdef KEYEXP_DEC_ORDER_EN
    if (rk_rd_dec_i) rd_sel_d = AES_LAST_IDX - rk_rd_idx_i;
`endif
    if (rk_rd_idx_i <= AES_LAST_IDX) rk_rd_data_o = rk_q[rd_sel_d];
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign keys_valid_o = keys_valid_q;

endmodule
